branch_control: RTL and testbench
=================================

# branch_control

Branch decision unit for the single-cycle datapath. It decodes the current instruction and drives the `UncondBr`/`BrTaken` controls consumed by the instruction path that owns the PC. It holds the architectural NZCV flag register, loading it from the ALU on flag-setting instructions, and evaluates B.cond against it. It also keeps a saturating count of taken branches for debug and performance readout.

## Interface
- `COUNT_W`, default 16: width of the taken-branch counter.

- `clk` in 1: system clock; all state updates on posedge.
- `startup` in 1: reset, synchronous, active-high.
- `instruction` in 32: current instruction word, valid for the whole cycle.
- `aluFlags` in 4: {N,Z,C,V} produced by the ALU for the current instruction.
- `regZero` in 1: 1 when the register read for CBZ/CBNZ (Rt) equals 0.
- `UncondBr` out 1: 1 selects the imm26 offset, 0 selects imm19 (to the PC path).
- `BrTaken` out 1: 1 makes next PC = PC + (offset<<2), 0 makes it PC + 4.
- `flags` out 4: registered {N,Z,C,V}.
- `flagWrite` out 1: current instruction sets flags (decode, combinational).
- `brCount` out `COUNT_W`: number of cycles with `BrTaken`=1, saturating.

## Operation
- Decode, combinational from `instruction`:
  - B: [31:26]=000101. UncondBr=1, BrTaken=1.
  - BL: [31:26]=100101. UncondBr=1, BrTaken=1. Linking is handled elsewhere.
  - CBZ: [31:24]=10110100. UncondBr=0, BrTaken=regZero.
  - CBNZ: [31:24]=10110101. UncondBr=0, BrTaken=~regZero.
  - B.cond: [31:24]=01010100 and [4]=0. UncondBr=0, BrTaken=cond([3:0], `flags`).
  - All other instructions: UncondBr=0, BrTaken=0.
- Condition evaluation uses the registered `flags`, never `aluFlags`:
  - EQ 0000: Z. NE 0001: !Z.
  - HS 0010: C. LO 0011: !C.
  - MI 0100: N. PL 0101: !N.
  - VS 0110: V. VC 0111: !V.
  - HI 1000: C&!Z. LS 1001: !(C&!Z).
  - GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: !Z&(N==V). LE 1101: !(!Z&(N==V)).
  - 1110 and 1111: always taken.
- flagWrite=1 when any of these match:
  - ADDS: [31:21]=10101011000.
  - SUBS: [31:21]=11101011000.
  - ANDS: [31:21]=11101010000.
  - ADDIS: [31:22]=1011000100.
  - SUBIS: [31:22]=1111000100.
- Flag register: on posedge, if `startup`, flags<=0. Else if flagWrite, flags<=aluFlags. Else it holds.
- Counter: on posedge, if `startup`, brCount<=0. Else if BrTaken and brCount!=all-ones, brCount<=brCount+1. At all-ones it holds.
- While `startup`=1, UncondBr and BrTaken are forced to 0 regardless of the instruction.

## Timing
- UncondBr, BrTaken and flagWrite are combinational with zero latency. They settle within the cycle the instruction is presented.
- A flag-setting instruction in cycle n affects a B.cond evaluated in cycle n+1 or later. A B.cond in the same cycle as a flag write sees the old flags.
- Reset values after a `startup` edge: flags=0000, brCount=0. UncondBr=0 and BrTaken=0 while `startup` is held.
- Asserting `startup` mid-program clears flags and brCount at the next edge. A branch presented in that cycle is not taken and not counted.
- A flag-setting instruction is never a branch, so there is no simultaneous-event conflict between flag load and branch decode.
- Unknown opcodes never set flags and never branch.

## Test plan
- Reset: hold `startup` 1 for one edge with instruction=0x14000007. Required: BrTaken=0, UncondBr=0, flags=0, brCount=0. Release `startup`: BrTaken=1, UncondBr=1, brCount=1 after the next edge.
- CBZ/CBNZ: instruction 0xB4FFFFE0. With regZero=1: UncondBr=0, BrTaken=1. With regZero=0: BrTaken=0. Then instruction 0xB5FFFFE0 with regZero=0: BrTaken=1.
- Flags and B.cond:
  - Cycle 0: SUBS 0xEB030041 with aluFlags=0100, so flagWrite=1.
  - Cycle 1: B.EQ 0x54000040 gives BrTaken=1. B.NE 0x54000041 gives BrTaken=0.
  - Same-cycle check: B.EQ presented in the SUBS cycle, with prior flags=0000, gives BrTaken=0.
- Flag hold: ADD immediate 0x91000400 with aluFlags=1111. Required: flagWrite=0 and flags unchanged. Then load flags=1001 (N=1,V=1) via SUBS and check:
  - GE (cond 1010): taken.
  - LT (cond 1011): not taken.
  - GT (cond 1100): taken.
- Full condition sweep: for each of the 16 NZCV values, present B.cond for all 16 cond codes. Compare BrTaken against the condition equations above.
- Saturation with COUNT_W=4: 20 consecutive B instructions. Required: brCount reaches 15 and holds at 15. Then `startup` clears it to 0.

Source files
------------

// File: rtl/branch_control.sv
// Branch decision unit: decodes branches, owns the NZCV register,
// evaluates B.cond and keeps a saturating taken-branch count.
module branch_control #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               startup,
  input  logic [31:0]        instruction,
  input  logic [3:0]         aluFlags,
  input  logic               regZero,
  output logic               UncondBr,
  output logic               BrTaken,
  output logic [3:0]         flags,
  output logic               flagWrite,
  output logic [COUNT_W-1:0] brCount
);

  logic is_b, is_bl, is_cbz, is_cbnz, is_bcond;
  logic is_adds, is_subs, is_ands, is_addis, is_subis;
  logic cond_ok, cond_base;
  logic dec_uncond, dec_taken;
  logic n, z, c, v;
  logic unused_bits;

  assign unused_bits = ^instruction[20:5];

  assign is_b     = instruction[31:26] == 6'b000101;
  assign is_bl    = instruction[31:26] == 6'b100101;
  assign is_cbz   = instruction[31:24] == 8'b10110100;
  assign is_cbnz  = instruction[31:24] == 8'b10110101;
  assign is_bcond = instruction[31:24] == 8'b01010100
                  && !instruction[4];

  assign is_adds  = instruction[31:21] == 11'b10101011000;
  assign is_subs  = instruction[31:21] == 11'b11101011000;
  assign is_ands  = instruction[31:21] == 11'b11101010000;
  assign is_addis = instruction[31:22] == 10'b1011000100;
  assign is_subis = instruction[31:22] == 10'b1111000100;

  assign flagWrite = is_adds | is_subs | is_ands
                   | is_addis | is_subis;

  assign {n, z, c, v} = flags;

  // Odd codes invert the even base, except 1111 (always).
  always_comb begin
    cond_base = 1'b1;
    unique case (instruction[3:1])
      3'b000: cond_base = z;
      3'b001: cond_base = c;
      3'b010: cond_base = n;
      3'b011: cond_base = v;
      3'b100: cond_base = c & ~z;
      3'b101: cond_base = n == v;
      3'b110: cond_base = ~z & (n == v);
      3'b111: cond_base = 1'b1;
    endcase
    cond_ok = cond_base;
    if (instruction[0] && instruction[3:1] != 3'b111)
      cond_ok = ~cond_base;
  end

  always_comb begin
    dec_uncond = 1'b0;
    dec_taken  = 1'b0;
    unique case (1'b1)
      is_b, is_bl: begin
        dec_uncond = 1'b1;
        dec_taken  = 1'b1;
      end
      is_cbz:   dec_taken = regZero;
      is_cbnz:  dec_taken = ~regZero;
      is_bcond: dec_taken = cond_ok;
      default: begin
        dec_uncond = 1'b0;
        dec_taken  = 1'b0;
      end
    endcase
  end

  assign UncondBr = dec_uncond & ~startup;
  assign BrTaken  = dec_taken & ~startup;

  always_ff @(posedge clk) begin
    if (startup)
      flags <= 4'b0000;
    else if (flagWrite)
      flags <= aluFlags;
  end

  always_ff @(posedge clk) begin
    if (startup)
      brCount <= '0;
    else if (BrTaken && !(&brCount))
      brCount <= brCount + 1'b1;
  end

endmodule

// File: tb/tb_branch_control.sv
// Directed bench for branch_control: decode, flags,
// condition sweep and counter saturation (COUNT_W=4).
module tb_branch_control;

  logic        clk = 1'b0;
  logic        startup;
  logic [31:0] instruction;
  logic [3:0]  aluFlags;
  logic        regZero;
  logic        UncondBr;
  logic        BrTaken;
  logic [3:0]  flags;
  logic        flagWrite;
  logic [3:0]  brCount;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] B_I   = 32'h1400_0007;
  localparam logic [31:0] SUBS  = 32'hEB03_0041;
  localparam logic [31:0] BCOND = 32'h5400_0040;

  branch_control #(.COUNT_W(4)) dut (
    .clk(clk),
    .startup(startup),
    .instruction(instruction),
    .aluFlags(aluFlags),
    .regZero(regZero),
    .UncondBr(UncondBr),
    .BrTaken(BrTaken),
    .flags(flags),
    .flagWrite(flagWrite),
    .brCount(brCount)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond_model(input logic [3:0] f,
                                      input logic [3:0] cc);
    logic fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (cc)
      4'h0: return fz;
      4'h1: return !fz;
      4'h2: return fc;
      4'h3: return !fc;
      4'h4: return fn;
      4'h5: return !fn;
      4'h6: return fv;
      4'h7: return !fv;
      4'h8: return fc && !fz;
      4'h9: return !(fc && !fz);
      4'hA: return fn == fv;
      4'hB: return fn != fv;
      4'hC: return !fz && (fn == fv);
      4'hD: return !(!fz && (fn == fv));
      default: return 1'b1;
    endcase
  endfunction

  logic [31:0] fw_ins [6];
  logic        fw_exp [6];

  initial begin
    fw_ins[0] = 32'hAB02_0020; fw_exp[0] = 1'b1;
    fw_ins[1] = 32'hEA02_0020; fw_exp[1] = 1'b1;
    fw_ins[2] = 32'hB100_0420; fw_exp[2] = 1'b1;
    fw_ins[3] = 32'hF100_0420; fw_exp[3] = 1'b1;
    fw_ins[4] = 32'h8B02_0020; fw_exp[4] = 1'b0;
    fw_ins[5] = 32'hFFFF_FFFF; fw_exp[5] = 1'b0;

    startup     = 1'b1;
    instruction = B_I;
    aluFlags    = 4'b0000;
    regZero     = 1'b0;

    cyc();
    check("rst_taken", BrTaken, 0);
    check("rst_uncond", UncondBr, 0);
    check("rst_flags", flags, 0);
    check("rst_cnt", brCount, 0);
    startup = 1'b0;
    #1;
    check("b_taken", BrTaken, 1);
    check("b_uncond", UncondBr, 1);
    cyc();
    check("b_cnt", brCount, 1);
    instruction = 32'h9400_0001;
    #1;
    check("bl_taken", BrTaken, 1);
    check("bl_uncond", UncondBr, 1);

    instruction = 32'hB4FF_FFE0;
    regZero = 1'b1;
    #1;
    check("cbz_uncond", UncondBr, 0);
    check("cbz_z1", BrTaken, 1);
    regZero = 1'b0;
    #1;
    check("cbz_z0", BrTaken, 0);
    instruction = 32'hB5FF_FFE0;
    #1;
    check("cbnz_z0", BrTaken, 1);
    regZero = 1'b1;
    #1;
    check("cbnz_z1", BrTaken, 0);
    instruction = 32'h5400_0050;
    #1;
    check("bcond_b4", BrTaken, 0);

    for (int i = 0; i < 6; i++) begin
      instruction = fw_ins[i];
      #1;
      check($sformatf("fw_%0d", i), flagWrite, fw_exp[i]);
      check($sformatf("fw_nobr_%0d", i), BrTaken, 0);
    end

    instruction = SUBS;
    aluFlags = 4'b0100;
    #1;
    check("subs_fw", flagWrite, 1);
    instruction = BCOND;
    #1;
    check("same_cyc_eq", BrTaken, 0);
    check("same_cyc_flags", flags, 0);
    instruction = SUBS;
    cyc();
    check("subs_flags", flags, 4'b0100);
    instruction = BCOND;
    #1;
    check("beq_taken", BrTaken, 1);
    instruction = BCOND | 32'h1;
    #1;
    check("bne_taken", BrTaken, 0);

    instruction = 32'h9100_0400;
    aluFlags = 4'b1111;
    #1;
    check("addi_fw", flagWrite, 0);
    cyc();
    check("hold_flags", flags, 4'b0100);
    instruction = SUBS;
    aluFlags = 4'b1001;
    cyc();
    check("nv_flags", flags, 4'b1001);
    instruction = BCOND | 32'hA;
    #1;
    check("ge", BrTaken, 1);
    instruction = BCOND | 32'hB;
    #1;
    check("lt", BrTaken, 0);
    instruction = BCOND | 32'hC;
    #1;
    check("gt", BrTaken, 1);

    for (int f = 0; f < 16; f++) begin
      instruction = SUBS;
      aluFlags = 4'(f);
      cyc();
      for (int cc = 0; cc < 16; cc++) begin
        instruction = BCOND | 32'(cc);
        #1;
        check($sformatf("sweep_f%0h_c%0h", f, cc),
              BrTaken, cond_model(4'(f), 4'(cc)));
      end
    end

    instruction = NOP;
    startup = 1'b1;
    cyc();
    check("mid_rst_flags", flags, 0);
    startup = 1'b0;
    instruction = B_I;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check($sformatf("sat_%0d", i), brCount,
            (i + 1 > 15) ? 15 : i + 1);
    end
    startup = 1'b1;
    #1;
    check("rst_force_tk", BrTaken, 0);
    check("rst_force_un", UncondBr, 0);
    cyc();
    check("sat_clear", brCount, 0);
    startup = 1'b0;
    instruction = NOP;
    cyc();
    check("nop_cnt", brCount, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
